// File: rtl/calc_pkg.sv
// Address and lane-select width helpers shared by the display command path.
package calc_pkg;

    function automatic int num_row_address_bits(input int pixel_height);
        return (pixel_height > 1) ? $clog2(pixel_height) : 1;
    endfunction

    function automatic int num_column_address_bits(input int pixel_width);
        return (pixel_width > 1) ? $clog2(pixel_width) : 1;
    endfunction

    function automatic int num_pixelcolorselect_bits(input int bytes_per_pixel);
        return (bytes_per_pixel > 1) ? $clog2(bytes_per_pixel) : 1;
    endfunction

    function automatic int num_fb_addr_bits(input int pixel_height, input int pixel_width);
        return num_row_address_bits(pixel_height) + num_column_address_bits(pixel_width);
    endfunction

endpackage

// File: rtl/params_pkg.sv
// Panel geometry and queue sizing defaults for the display datapath.
package params_pkg;

    localparam int BYTES_PER_PIXEL = 2;
    localparam int PIXEL_HEIGHT    = 64;
    localparam int PIXEL_WIDTH     = 128;
    localparam int FIFO_DEPTH      = 2;

endpackage

// File: rtl/pixel_write_assembler_pkg.sv
// Framebuffer write entry layout at the default panel geometry: address above data.
package pixel_write_assembler_pkg;

    typedef struct packed {
        logic [calc_pkg::num_fb_addr_bits(params_pkg::PIXEL_HEIGHT, params_pkg::PIXEL_WIDTH)-1:0] addr;
        logic [8*params_pkg::BYTES_PER_PIXEL-1:0]                                               data;
    } fb_wr_entry_t;

endpackage

// File: rtl/fb_write_fifo.sv
// Shift-style queue of completed pixels; slot 0 is always the registered head.
module fb_write_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r    [DEPTH];
    logic [WIDTH-1:0] mem_next [DEPTH];
    logic [IW:0]      count_r, count_next;
    logic             full_r, empty_r;
    logic             do_pop, do_push;

    // Pop shifts toward the head; a push lands behind the surviving entries.
    always_comb begin
        do_pop     = pop && !empty_r;
        do_push    = push && (!full_r || do_pop);
        mem_next   = mem_r;
        count_next = count_r;
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_next[i] = mem_r[i+1];
            end
            mem_next[DEPTH-1] = '0;
            count_next        = count_r - {{IW{1'b0}}, 1'b1};
        end else begin
            count_next = count_r;
        end
        if (do_push) begin
            mem_next[count_next[IW-1:0]] = push_data;
            count_next                   = count_next + {{IW{1'b0}}, 1'b1};
        end else begin
            count_next = count_next;
        end
    end

    // Queue storage and registered status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            count_r <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            mem_r   <= mem_next;
            count_r <= count_next;
            empty_r <= (count_next == '0);
            full_r  <= (count_next == (IW+1)'(DEPTH));
        end
    end

    assign head  = mem_r[0];
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/pixel_write_assembler.sv
// Collects MSB-first byte strobes into whole pixels and queues them as atomic framebuffer writes.
module pixel_write_assembler
    import pixel_write_assembler_pkg::*;
#(
    parameter int BYTES_PER_PIXEL = params_pkg::BYTES_PER_PIXEL,
    parameter int PIXEL_HEIGHT    = params_pkg::PIXEL_HEIGHT,
    parameter int PIXEL_WIDTH     = params_pkg::PIXEL_WIDTH,
    parameter int FIFO_DEPTH      = params_pkg::FIFO_DEPTH
) (
    input  logic                                                        clk,
    input  logic                                                        reset,
    input  logic [calc_pkg::num_row_address_bits(PIXEL_HEIGHT)-1:0]     row,
    input  logic [calc_pkg::num_column_address_bits(PIXEL_WIDTH)-1:0]   column,
    input  logic [calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL)-1:0] pixel,
    input  logic [7:0]                                                  data_in,
    input  logic                                                        ram_write_enable,
    input  logic                                                        ram_access_start,
    input  logic                                                        done,
    output logic                                                        fb_wr_valid,
    input  logic                                                        fb_wr_ready,
    output logic [calc_pkg::num_fb_addr_bits(PIXEL_HEIGHT, PIXEL_WIDTH)-1:0] fb_wr_addr,
    output logic [8*BYTES_PER_PIXEL-1:0]                                fb_wr_data,
    output logic                                                        busy,
    output logic                                                        err_overflow,
    output logic                                                        err_partial,
    output logic [15:0]                                                 pixel_count
);
    localparam int AW   = calc_pkg::num_fb_addr_bits(PIXEL_HEIGHT, PIXEL_WIDTH);
    localparam int DW   = 8 * BYTES_PER_PIXEL;
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

    logic [BYTES_PER_PIXEL-1:0] mask_r, mask_next;
    logic [DW-1:0]              word_r, word_next;
    logic [AW-1:0]              addr_r, addr_next;
    logic [AW-1:0]              wr_addr;
    logic                       push_cand, part_err;
    logic                       pop_s, push_ok, ovf_s;
    logic                       fifo_full, fifo_empty;
    logic [AW+DW-1:0]           fifo_head;
    logic [CNTW-1:0]            fifo_count, occ_next;
    logic                       busy_r, err_overflow_r, err_partial_r;
    logic [15:0]                pixel_count_r;

    assign wr_addr = {row, column};

    // Lane bookkeeping: start clears first, then the byte, then an end-of-command check.
    always_comb begin
        mask_next = mask_r;
        word_next = word_r;
        addr_next = addr_r;
        push_cand = 1'b0;
        part_err  = 1'b0;
        if (ram_access_start) begin
            mask_next = '0;
        end else begin
            mask_next = mask_r;
        end
        if (ram_write_enable) begin
            if (int'(pixel) >= BYTES_PER_PIXEL) begin
                part_err = 1'b1;
            end else begin
                if ((mask_next != '0) && (wr_addr != addr_r)) begin
                    mask_next = '0;
                    part_err  = 1'b1;
                end else begin
                    mask_next = mask_next;
                end
                word_next[8*int'(pixel) +: 8] = data_in;
                mask_next[pixel]              = 1'b1;
                addr_next                     = wr_addr;
                if (pixel == '0) begin
                    if (&mask_next) begin
                        push_cand = 1'b1;
                    end else begin
                        part_err = 1'b1;
                    end
                    mask_next = '0;
                end else begin
                    push_cand = 1'b0;
                end
            end
        end else begin
            push_cand = 1'b0;
        end
        if (done && (mask_next != '0)) begin
            mask_next = '0;
            part_err  = 1'b1;
        end else begin
            part_err = part_err;
        end
    end

    // A pop frees a slot this cycle, so full-with-pop still accepts the new pixel.
    assign pop_s    = fb_wr_valid && fb_wr_ready;
    assign push_ok  = push_cand && (!fifo_full || pop_s);
    assign ovf_s    = push_cand && fifo_full && !pop_s;
    assign occ_next = fifo_count - {{(CNTW-1){1'b0}}, pop_s} + {{(CNTW-1){1'b0}}, push_ok};

    // Assembly state, sticky errors, accepted-pixel counter and busy flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mask_r         <= '0;
            word_r         <= '0;
            addr_r         <= '0;
            busy_r         <= 1'b0;
            err_overflow_r <= 1'b0;
            err_partial_r  <= 1'b0;
            pixel_count_r  <= 16'h0000;
        end else begin
            mask_r         <= mask_next;
            word_r         <= word_next;
            addr_r         <= addr_next;
            busy_r         <= (mask_next != '0) || (occ_next != '0);
            err_overflow_r <= err_overflow_r | ovf_s;
            err_partial_r  <= err_partial_r | part_err;
            if (push_ok && (pixel_count_r != 16'hFFFF)) begin
                pixel_count_r <= pixel_count_r + 16'h0001;
            end else begin
                pixel_count_r <= pixel_count_r;
            end
        end
    end

    fb_write_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_cand),
        .pop       (fb_wr_ready),
        .push_data ({addr_next, word_next}),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign fb_wr_valid  = !fifo_empty;
    assign fb_wr_addr   = fifo_head[AW+DW-1:DW];
    assign fb_wr_data   = fifo_head[DW-1:0];
    assign busy         = busy_r;
    assign err_overflow = err_overflow_r;
    assign err_partial  = err_partial_r;
    assign pixel_count  = pixel_count_r;

endmodule

// File: tb/tb_pixel_write_assembler.sv
// Directed vector table, hand sequences for queue corner cases, then random traffic against a queue model.
module tb_pixel_write_assembler;

    localparam int BPP   = 2;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row, column;
    logic [0:0]  pixel;
    logic [7:0]  data_in;
    logic        ram_write_enable, ram_access_start, done, fb_wr_ready;
    logic        fb_wr_valid, busy, err_overflow, err_partial;
    logic [7:0]  fb_wr_addr;
    logic [15:0] fb_wr_data, pixel_count;

    int n_checks = 0;
    int n_pass   = 0;

    pixel_write_assembler #(
        .BYTES_PER_PIXEL (BPP),
        .PIXEL_HEIGHT    (16),
        .PIXEL_WIDTH     (16),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .row              (row),
        .column           (column),
        .pixel            (pixel),
        .data_in          (data_in),
        .ram_write_enable (ram_write_enable),
        .ram_access_start (ram_access_start),
        .done             (done),
        .fb_wr_valid      (fb_wr_valid),
        .fb_wr_ready      (fb_wr_ready),
        .fb_wr_addr       (fb_wr_addr),
        .fb_wr_data       (fb_wr_data),
        .busy             (busy),
        .err_overflow     (err_overflow),
        .err_partial      (err_partial),
        .pixel_count      (pixel_count)
    );

    always #5 clk = ~clk;

    // Expected outputs packed as {valid, addr, data, busy, err_overflow, err_partial, pixel_count}.
    function automatic logic [43:0] ex(input logic v, input logic [7:0] a, input logic [15:0] d,
                                       input logic b, input logic eo, input logic ep,
                                       input logic [15:0] c);
        return {v, a, d, b, eo, ep, c};
    endfunction

    typedef struct {
        logic        rst;
        logic [3:0]  r;
        logic [3:0]  c;
        logic        pix;
        logic [7:0]  d;
        logic        we;
        logic        st;
        logic        dn;
        logic        rdy;
        logic [43:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] r, input logic [3:0] c,
                                input logic pix, input logic [7:0] d, input logic we,
                                input logic st, input logic dn, input logic rdy,
                                input logic [43:0] exp);
        vec_t v;
        v.rst = rst; v.r = r; v.c = c; v.pix = pix; v.d = d;
        v.we = we; v.st = st; v.dn = dn; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    task automatic cyc(input logic rst, input logic [3:0] r, input logic [3:0] c, input logic pix,
                       input logic [7:0] d, input logic we, input logic st, input logic dn,
                       input logic rdy);
        reset = rst; row = r; column = c; pixel = pix; data_in = d;
        ram_write_enable = we; ram_access_start = st; done = dn; fb_wr_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [43:0] exp);
        logic [43:0] act;
        act = {fb_wr_valid, fb_wr_addr, fb_wr_data, busy, err_overflow, err_partial, pixel_count};
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got v=%b a=%h d=%h busy=%b eo=%b ep=%b cnt=%0d, expected v=%b a=%h d=%h busy=%b eo=%b ep=%b cnt=%0d",
                      name, act[43], act[42:35], act[34:19], act[18], act[17], act[16], act[15:0],
                      exp[43], exp[42:35], exp[34:19], exp[18], exp[17], exp[16], exp[15:0]);
    endtask

    // Reference model: a queue of pending pixels plus the set of lanes collected so far.
    typedef struct { logic [7:0] a; logic [15:0] d; } ent_t;
    ent_t       mq[$];
    bit         have[BPP];
    logic [7:0] byt[BPP];
    logic [7:0] paddr;
    bit         m_eo, m_ep;
    int         m_cnt;

    function automatic bit any_lane();
        bit r = 0;
        for (int k = 0; k < BPP; k++) r |= have[k];
        return r;
    endfunction

    function automatic bit all_lanes();
        bit r = 1;
        for (int k = 0; k < BPP; k++) r &= have[k];
        return r;
    endfunction

    function automatic void clear_lanes();
        for (int k = 0; k < BPP; k++) have[k] = 0;
    endfunction

    function automatic logic [43:0] model_step(input vec_t v);
        bit   pop, cand;
        ent_t e;
        if (!v.rst) begin
            mq.delete(); clear_lanes(); m_eo = 0; m_ep = 0; m_cnt = 0;
        end else begin
            pop  = (mq.size() > 0) && v.rdy;
            cand = 0;
            if (v.st) clear_lanes();
            if (v.we) begin
                if (int'(v.pix) >= BPP) m_ep = 1;
                else begin
                    if (any_lane() && ({v.r, v.c} != paddr)) begin clear_lanes(); m_ep = 1; end
                    byt[v.pix] = v.d; have[v.pix] = 1; paddr = {v.r, v.c};
                    if (v.pix == 1'b0) begin
                        if (all_lanes()) begin cand = 1; e.a = paddr; e.d = {byt[1], byt[0]}; end
                        else m_ep = 1;
                        clear_lanes();
                    end
                end
            end
            if (v.dn && any_lane()) begin clear_lanes(); m_ep = 1; end
            if (pop) void'(mq.pop_front());
            if (cand) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(e);
                    if (m_cnt < 65535) m_cnt++;
                end else m_eo = 1;
            end
        end
        if (mq.size() > 0)
            return ex(1'b1, mq[0].a, mq[0].d, 1'b1, m_eo, m_ep, 16'(m_cnt));
        return ex(1'b0, 8'h00, 16'h0000, any_lane(), m_eo, m_ep, 16'(m_cnt));
    endfunction

    vec_t tbl[$];

    initial begin
        // Directed table: single pixel, address mismatch, done/start aborts, start+write ordering.
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, ex(0, 8'h00, 16'h0000, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 1, ex(0, 8'h00, 16'h0000, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 3, 5, 1, 8'hAB, 1, 0, 0, 1, ex(0, 8'h00, 16'h0000, 1, 0, 0, 0)));
        tbl.push_back(mk(1, 3, 5, 0, 8'hCD, 1, 0, 0, 1, ex(1, 8'h35, 16'hABCD, 1, 0, 0, 1)));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 1, ex(0, 8'h00, 16'h0000, 0, 0, 0, 1)));
        tbl.push_back(mk(1, 3, 5, 1, 8'h11, 1, 0, 0, 1, ex(0, 8'h00, 16'h0000, 1, 0, 0, 1)));
        tbl.push_back(mk(1, 3, 6, 0, 8'h22, 1, 0, 0, 1, ex(0, 8'h00, 16'h0000, 0, 0, 1, 1)));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, ex(0, 8'h00, 16'h0000, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 1, ex(0, 8'h00, 16'h0000, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 1, 2, 1, 8'hAA, 1, 0, 0, 1, ex(0, 8'h00, 16'h0000, 1, 0, 0, 0)));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 1, 1, ex(0, 8'h00, 16'h0000, 0, 0, 1, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, ex(0, 8'h00, 16'h0000, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 1, 2, 1, 8'hAA, 1, 0, 0, 1, ex(0, 8'h00, 16'h0000, 1, 0, 0, 0)));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 1, 0, 1, ex(0, 8'h00, 16'h0000, 0, 0, 0, 0)));
        tbl.push_back(mk(1, 1, 2, 1, 8'h55, 1, 1, 0, 1, ex(0, 8'h00, 16'h0000, 1, 0, 0, 0)));
        tbl.push_back(mk(1, 1, 2, 0, 8'h66, 1, 0, 0, 1, ex(1, 8'h12, 16'h5566, 1, 0, 0, 1)));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 1, ex(0, 8'h00, 16'h0000, 0, 0, 0, 1)));
        tbl.push_back(mk(1, 2, 3, 1, 8'h77, 1, 0, 0, 1, ex(0, 8'h00, 16'h0000, 1, 0, 0, 1)));
        tbl.push_back(mk(1, 2, 3, 0, 8'h88, 1, 1, 0, 1, ex(0, 8'h00, 16'h0000, 0, 0, 1, 1)));
        tbl.push_back(mk(1, 2, 3, 1, 8'h99, 1, 0, 0, 1, ex(0, 8'h00, 16'h0000, 1, 0, 1, 1)));
        tbl.push_back(mk(1, 2, 3, 0, 8'hEE, 1, 0, 1, 1, ex(1, 8'h23, 16'h99EE, 1, 0, 1, 2)));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 1, ex(0, 8'h00, 16'h0000, 0, 0, 1, 2)));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].r, tbl[i].c, tbl[i].pix, tbl[i].d,
                tbl[i].we, tbl[i].st, tbl[i].dn, tbl[i].rdy);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Overflow with ready held low, then draining in order.
        cyc(0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 8'hA1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 8'hB1, 1, 0, 0, 0);
        check("ovf_p1", ex(1, 8'h11, 16'hA1B1, 1, 0, 0, 1));
        cyc(1, 2, 2, 1, 8'hA2, 1, 0, 0, 0);
        cyc(1, 2, 2, 0, 8'hB2, 1, 0, 0, 0);
        check("ovf_p2", ex(1, 8'h11, 16'hA1B1, 1, 0, 0, 2));
        cyc(1, 3, 3, 1, 8'hA3, 1, 0, 0, 0);
        check("ovf_p3_lane1", ex(1, 8'h11, 16'hA1B1, 1, 0, 0, 2));
        cyc(1, 3, 3, 0, 8'hB3, 1, 0, 0, 0);
        check("ovf_p3_drop", ex(1, 8'h11, 16'hA1B1, 1, 1, 0, 2));
        cyc(1, 0, 0, 0, 8'h00, 0, 0, 0, 1);
        check("ovf_pop1", ex(1, 8'h22, 16'hA2B2, 1, 1, 0, 2));
        cyc(1, 0, 0, 0, 8'h00, 0, 0, 0, 1);
        check("ovf_pop2", ex(0, 8'h00, 16'h0000, 0, 1, 0, 2));

        // Push and pop together while full.
        cyc(0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        cyc(1, 4, 4, 1, 8'hC1, 1, 0, 0, 0);
        cyc(1, 4, 4, 0, 8'hD1, 1, 0, 0, 0);
        cyc(1, 5, 5, 1, 8'hC2, 1, 0, 0, 0);
        cyc(1, 5, 5, 0, 8'hD2, 1, 0, 0, 0);
        check("pp_full", ex(1, 8'h44, 16'hC1D1, 1, 0, 0, 2));
        cyc(1, 6, 6, 1, 8'hC3, 1, 0, 0, 0);
        cyc(1, 6, 6, 0, 8'hD3, 1, 0, 0, 1);
        check("pp_same_cycle", ex(1, 8'h55, 16'hC2D2, 1, 0, 0, 3));
        cyc(1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        check("pp_hold", ex(1, 8'h55, 16'hC2D2, 1, 0, 0, 3));
        cyc(1, 0, 0, 0, 8'h00, 0, 0, 0, 1);
        check("pp_pop_q3", ex(1, 8'h66, 16'hC3D3, 1, 0, 0, 3));
        cyc(1, 0, 0, 0, 8'h00, 0, 0, 0, 1);
        check("pp_empty", ex(0, 8'h00, 16'h0000, 0, 0, 0, 3));

        // Reset mid-pixel with one queued entry, then normal assembly.
        cyc(0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        cyc(1, 7, 7, 1, 8'hE1, 1, 0, 0, 0);
        cyc(1, 7, 7, 0, 8'hF1, 1, 0, 0, 0);
        cyc(1, 8, 8, 1, 8'hE2, 1, 0, 0, 0);
        check("rst_pre", ex(1, 8'h77, 16'hE1F1, 1, 0, 0, 1));
        cyc(0, 8, 8, 0, 8'hF2, 0, 0, 0, 0);
        check("rst_mid", ex(0, 8'h00, 16'h0000, 0, 0, 0, 0));
        cyc(1, 9, 9, 1, 8'h12, 1, 0, 0, 1);
        cyc(1, 9, 9, 0, 8'h34, 1, 0, 0, 1);
        check("rst_after", ex(1, 8'h99, 16'h1234, 1, 0, 0, 1));
        cyc(1, 0, 0, 0, 8'h00, 0, 0, 0, 1);
        check("rst_after_pop", ex(0, 8'h00, 16'h0000, 0, 0, 0, 1));

        // Random traffic on a few addresses so matches, mismatches and overflow all occur.
        begin
            vec_t        v;
            logic [43:0] exp;
            v = mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 44'h0);
            exp = model_step(v);
            cyc(v.rst, v.r, v.c, v.pix, v.d, v.we, v.st, v.dn, v.rdy);
            check("rand_reset", exp);
            for (int i = 0; i < 2000; i++) begin
                v.rst = ($urandom_range(63) != 0);
                v.r   = 4'($urandom_range(1));
                v.c   = 4'($urandom_range(1));
                v.pix = 1'($urandom_range(1));
                v.d   = 8'($urandom);
                v.we  = ($urandom_range(9) < 7);
                v.st  = ($urandom_range(15) == 0);
                v.dn  = ($urandom_range(15) == 0);
                v.rdy = ($urandom_range(1) == 1);
                exp = model_step(v);
                cyc(v.rst, v.r, v.c, v.pix, v.d, v.we, v.st, v.dn, v.rdy);
                check($sformatf("rand%0d", i), exp);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
